// File: rtl/request_queue.sv
// In-order request FIFO between the trace parser and the DRAM scheduler; owns the
// simulation time base. Optional per-event logging: define REQUEST_QUEUE_LOG_EN.
module request_queue #(
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [1:0]                 in_opcode,
    input  logic [ADDRESS_WIDTH-1:0]   in_address,
    input  logic [31:0]                in_time,
    output logic [31:0]                queue_time,
    output logic                       queue_full,
    output logic                       pending_request,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_opcode,
    output logic [ADDRESS_WIDTH-1:0]   out_address,
    output logic [31:0]                out_time,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 + ADDRESS_WIDTH + 32;
    localparam logic [1:0] OP_NOP = 2'd3;

    logic [EW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    queue_time_q, queue_time_d;
    logic           queue_full_q, queue_full_d;
    logic           pending_q, pending_d;
    logic           req_live, enq, deq, skip;

    always_comb begin
        req_live = in_valid && (in_opcode != OP_NOP);
        enq      = req_live && (in_time <= queue_time_q) && (count_q != CW'(DEPTH));
        deq      = (count_q != '0) && out_ready;
        // Jump over idle time only when nothing is buffered and the parser is waiting.
        skip     = (count_q == '0) && !enq && req_live && (in_time > queue_time_q + 32'd1);

        wr_ptr_d     = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
        queue_time_d = skip ? in_time : queue_time_q + 32'd1;

        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        queue_full_d = (count_d == CW'(DEPTH));
        pending_d    = req_live && !enq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            queue_time_q <= '0;
            queue_full_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            queue_time_q <= queue_time_d;
            queue_full_q <= queue_full_d;
            pending_q    <= pending_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && enq)
            mem_q[wr_ptr_q] <= {in_opcode, in_address, in_time};
    end

`ifdef REQUEST_QUEUE_LOG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (enq)
                $display("%0d ENQ %0d %0h %0d %0d", queue_time_q, in_opcode, in_address, in_time, count_q);
            if (deq)
                $display("%0d DEQ %0d %0h %0d %0d", queue_time_q, out_opcode, out_address, out_time, count_q);
            if (skip)
                $display("%0d SKIP %0d %0h %0d %0d", queue_time_q, in_opcode, in_address, in_time, count_q);
        end
    end
`else
`endif

    assign {out_opcode, out_address, out_time} = mem_q[rd_ptr_q];
    assign out_valid       = (count_q != '0);
    assign count           = count_q;
    assign queue_time      = queue_time_q;
    assign queue_full      = queue_full_q;
    assign pending_request = pending_q;
endmodule

// File: tb/tb_request_queue.sv
// Directed bench for request_queue: reset, time skip, full/backpressure, streaming,
// mid-run reset, NOP handling and time-base wrap.
module tb_request_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_opcode = 2'd0;
    logic [32:0] in_address = '0;
    logic [31:0] in_time = '0;
    logic        out_ready = 1'b0;
    logic [31:0] queue_time;
    logic        queue_full, pending_request, out_valid;
    logic [1:0]  out_opcode;
    logic [32:0] out_address;
    logic [31:0] out_time;
    logic [4:0]  count;

    int vectors = 0;
    int errors  = 0;

    request_queue #(.DEPTH(16), .ADDRESS_WIDTH(33)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_address(in_address), .in_time(in_time), .queue_time(queue_time),
        .queue_full(queue_full), .pending_request(pending_request),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_address(out_address), .out_time(out_time), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset held three cycles, then free-running time base
        tick(); tick(); tick();
        chk("rst_qt", 64'(queue_time), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_full", 64'(queue_full), 64'd0);
        chk("rst_pending", 64'(pending_request), 64'd0);
        rst = 1'b0;
        tick();
        chk("qt_1", 64'(queue_time), 64'd1);
        tick();
        chk("qt_2", 64'(queue_time), 64'd2);
        tick(); tick(); tick();
        chk("qt_5", 64'(queue_time), 64'd5);

        // 2: future request on empty queue skips time, then enqueues
        in_valid = 1'b1; in_opcode = 2'd0; in_address = 33'h1_0000_0040; in_time = 32'd100;
        tick();
        chk("skip_qt", 64'(queue_time), 64'd100);
        chk("skip_pending", 64'(pending_request), 64'd1);
        chk("skip_count", 64'(count), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("enq_qt", 64'(queue_time), 64'd101);
        chk("enq_count", 64'(count), 64'd1);
        chk("enq_pending", 64'(pending_request), 64'd0);
        chk("enq_out_valid", 64'(out_valid), 64'd1);
        chk("enq_out_time", 64'(out_time), 64'd100);
        chk("enq_out_addr", 64'(out_address), 64'h1_0000_0040);
        chk("enq_out_op", 64'(out_opcode), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_count", 64'(count), 64'd0);
        chk("pop_out_valid", 64'(out_valid), 64'd0);

        // 3: fill to 16, 17th held until a pop frees a slot
        in_valid = 1'b1; in_opcode = 2'd1; in_time = 32'd0;
        for (int i = 0; i < 16; i++) begin
            in_address = 33'(i);
            tick();
        end
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_full", 64'(queue_full), 64'd1);
        chk("fill_pending", 64'(pending_request), 64'd0);
        in_address = 33'd16;
        tick();
        chk("held_count", 64'(count), 64'd16);
        chk("held_pending", 64'(pending_request), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("nobypass_count", 64'(count), 64'd15);
        chk("nobypass_full", 64'(queue_full), 64'd0);
        chk("nobypass_pending", 64'(pending_request), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("refill_count", 64'(count), 64'd16);
        chk("refill_full", 64'(queue_full), 64'd1);
        chk("refill_pending", 64'(pending_request), 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_addr", 64'(out_address), 64'(i));
            chk("drain_op", 64'(out_opcode), 64'd1);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_full", 64'(queue_full), 64'd0);

        // 4: hold occupancy at 4 with simultaneous push/pop across pointer wrap
        in_valid = 1'b1; in_opcode = 2'd2;
        for (int i = 0; i < 4; i++) begin
            in_address = 33'h200 + 33'(i);
            tick();
        end
        chk("stream_pre_count", 64'(count), 64'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_address = 33'h204 + 33'(k);
            chk("stream_addr", 64'(out_address), 64'h200 + 64'(k));
            tick();
            chk("stream_count", 64'(count), 64'd4);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("stream_head", 64'(out_address), 64'h214);

        // 5: reset with 7 entries discards everything
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_address = 33'h300 + 33'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_qt", 64'(queue_time), 64'd0);
        chk("midrst_full", 64'(queue_full), 64'd0);

        // 6: NOP is consumed without storing or flagging pending
        in_valid = 1'b1; in_opcode = 2'd3; in_time = 32'd0; in_address = 33'h3ff;
        tick();
        chk("nop_count", 64'(count), 64'd0);
        chk("nop_pending", 64'(pending_request), 64'd0);
        chk("nop_qt", 64'(queue_time), 64'd1);
        in_opcode = 2'd0;
        tick(); tick();
        chk("nop_pre_count", 64'(count), 64'd2);
        in_opcode = 2'd3;
        tick();
        chk("nop_busy_count", 64'(count), 64'd2);
        chk("nop_busy_pending", 64'(pending_request), 64'd0);

        // time base wrap: skip to 2^32-1, then roll to 0 on enqueue
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1; in_opcode = 2'd0; in_address = 33'h0_dead_beef; in_time = 32'hFFFF_FFFF;
        tick();
        chk("wrap_skip_qt", 64'(queue_time), 64'hFFFF_FFFF);
        chk("wrap_skip_pending", 64'(pending_request), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("wrap_qt", 64'(queue_time), 64'd0);
        chk("wrap_count", 64'(count), 64'd1);
        chk("wrap_out_time", 64'(out_time), 64'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
